// File: rtl/top.sv
// top: AXI4-Stream loopback with an internal packet generator feeding an internal sink.
module top #(
   parameter int DATA_W  = 8,
   parameter int PKT_LEN = 4
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              newd,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   localparam int CW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
   typedef enum logic {IDLE, SEND} state_t;
   state_t            state_q;
   logic [CW-1:0]     cnt_q, rx_cnt_q;
   logic              tvalid_q, tlast_q, tready_q, err_q;
   logic [DATA_W-1:0] tdata_q, dout_q;
   logic              xfer;
   assign xfer = tvalid_q & tready_q;
   assign dout = dout_q;
   // tdata advances by one per accepted beat, which equals seed + beat count
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else if (state_q == IDLE) begin
         if (newd) begin
            state_q  <= SEND;
            cnt_q    <= '0;
            tvalid_q <= 1'b1;
            tlast_q  <= (LAST == '0);
            tdata_q  <= din;
         end
      end else if (xfer) begin
         if (tlast_q) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_q + CW'(1);
            tdata_q <= tdata_q + DATA_W'(1);
            tlast_q <= (cnt_q + CW'(1) == LAST);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (areset) begin
         tready_q <= 1'b0;
         dout_q   <= '0;
         rx_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         tready_q <= 1'b1;
         if (xfer) begin
            dout_q   <= tdata_q;
            rx_cnt_q <= tlast_q ? '0 : rx_cnt_q + CW'(1);
            err_q    <= err_q | (tlast_q && rx_cnt_q != LAST);
         end
      end
   end
endmodule

// File: tb/tb_top.sv
// tb_top: randomized packet stimulus against a seed+k reference model of the loopback.
module tb_top;
   localparam int PL = 4;
   logic       clk = 1'b0;
   logic       areset = 1'b1;
   logic       newd = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   int         checks = 0;
   int         failures = 0;
   top #(.DATA_W(8), .PKT_LEN(PL)) dut (.clk(clk), .areset(areset), .newd(newd), .din(din), .dout(dout));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // newd is held for `hold` sampling edges starting at the request edge
   task automatic send(input logic [7:0] seed, input int hold);
      logic [7:0] e;
      din  = seed;
      newd = 1'b1;
      tick;
      check("tvalid_up", {31'b0, dut.tvalid_q}, 32'd1);
      for (int k = 0; k < PL; k++) begin
         newd = (k + 1 < hold);
         e = seed + 8'(k);
         check("tlast", {31'b0, dut.tlast_q}, {31'b0, k == PL - 1});
         check("tdata", {24'b0, dut.tdata_q}, {24'b0, e});
         tick;
         check("dout_beat", {24'b0, dout}, {24'b0, e});
      end
      newd = 1'b0;
      check("tvalid_end", {31'b0, dut.tvalid_q}, 32'd0);
      e = seed + 8'(PL - 1);
      repeat (3) tick;
      check("dout_hold", {24'b0, dout}, {24'b0, e});
      check("idle", {31'b0, dut.tvalid_q}, 32'd0);
   endtask
   initial begin
      logic [7:0] s;
      #1;
      repeat (10) tick;
      check("rst_dout", {24'b0, dout}, 32'd0);
      check("rst_tvalid", {31'b0, dut.tvalid_q}, 32'd0);
      check("rst_tready", {31'b0, dut.tready_q}, 32'd0);
      areset = 1'b0;
      tick;
      check("tready_rel", {31'b0, dut.tready_q}, 32'd1);
      send(8'h05, 1);
      send(8'h0A, 5);
      send(8'hFE, 1);
      din  = 8'h20;
      newd = 1'b1;
      tick;
      newd = 1'b0;
      tick;
      tick;
      check("mid_dout", {24'b0, dout}, 32'h21);
      areset = 1'b1;
      tick;
      check("abort_dout", {24'b0, dout}, 32'd0);
      check("abort_tvalid", {31'b0, dut.tvalid_q}, 32'd0);
      areset = 1'b0;
      tick;
      tick;
      check("abort_quiet", {24'b0, dout}, 32'd0);
      send(8'h03, 1);
      for (int p = 0; p < 10; p++) begin
         s = 8'($urandom_range(0, 15));
         send(s, 1 + int'($urandom_range(0, PL)));
         repeat (2) tick;
      end
      check("err_bit", {31'b0, dut.err_q}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
